// File: rtl/a0_trace_pkg.sv
// Shared defaults and occupancy-width helper for the a0 trace capture block.
package a0_trace_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DROP_W     = 16;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(DEF_DEPTH):0] cnt_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead single-clock FIFO; a push lands on out_data one cycle later when empty.
// Backpressure: push is refused only when full with no pop on the same edge.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop_req,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    pop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  wr;

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = pop_req && out_valid;
  // A pop on the same edge frees the slot the push needs.
  assign wr        = push && (!full || pop);
  assign out_data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/a0_trace_fifo.sv
// Records each change of the CPU a0 register into a FIFO; one cycle capture-to-output.
// Never stalls the CPU: samples arriving while full are dropped, counted and flagged.
module a0_trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DROP_W     = DEF_DROP_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        a0,
  input  logic                         en,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_w(DEPTH)-1:0]      count,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_cnt
);
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_ok;
  logic                  cap;
  logic                  full;
  logic                  pop;
  logic                  drop;

  assign cap  = en && (!prev_ok || (a0 != prev));
  assign drop = cap && full && !pop;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap),
    .push_data (a0),
    .pop_req   (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (count),
    .full      (full),
    .pop       (pop)
  );

  // prev tracks the last captured value even when its push was dropped,
  // so a held value is not retried every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      prev_ok  <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (cap) begin
        prev    <= a0;
        prev_ok <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_a0_trace_fifo.sv
// Bench for a0_trace_fifo: fixed vector table, corner-case sequences, random traffic vs a queue model.
module tb_a0_trace_fifo;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   a0 = '0;
  logic            en = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic            overflow;
  logic [DROP_W-1:0] drop_cnt;

  a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .a0(a0), .en(en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the FIFO is just a queue of captured values.
  int unsigned q[$];
  int unsigned m_prev = 0;
  bit          m_prev_ok = 0;
  bit          m_ovf = 0;
  int          m_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit do_pop, do_cap;
    if (rst) begin
      q.delete();
      m_prev_ok = 0;
      m_ovf = 0;
      m_drop = 0;
    end else begin
      do_pop = out_ready && (q.size() > 0);
      do_cap = en && (!m_prev_ok || a0 != m_prev);
      if (do_pop) void'(q.pop_front());
      if (do_cap) begin
        m_prev = a0;
        m_prev_ok = 1;
        if (q.size() < DEPTH) q.push_back(a0);
        else begin
          m_ovf = 1;
          if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end
      end
    end
  endtask

  task automatic apply(input bit r, input bit e, input int unsigned a, input bit rdy);
    rst = r; en = e; a0 = a; out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk({tag, ".data"}, 64'(out_data), 64'(q[0]));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  typedef struct {
    bit r; bit e; int unsigned a; bit rdy;
    int cnt; bit vld; int unsigned data; bit ovf; int drop;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, int unsigned a, bit rdy,
                              int cnt, bit vld, int unsigned data);
    vec_t v;
    v.r = r; v.e = e; v.a = a; v.rdy = rdy;
    v.cnt = cnt; v.vld = vld; v.data = data; v.ovf = 0; v.drop = 0;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    // rst, en, a0, ready -> count, valid, data after the edge
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 1, 0);   // first sample captured even though 0
    tbl[2]  = mk(0, 1, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 5, 1, 1, 1, 5);
    tbl[6]  = mk(0, 1, 5, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 7, 1, 1, 1, 7);
    tbl[8]  = mk(0, 1, 7, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 7, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 9, 1, 1, 1, 9);
    tbl[11] = mk(0, 1, 9, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 3, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 4, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 5, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 5, 0, 1, 1, 5);   // compared against prev=9, not the hidden 3,4
    tbl[16] = mk(0, 1, 5, 0, 1, 1, 5);

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].rdy);
      chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.valid", i), 64'(out_valid), 64'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl%0d.data", i), 64'(out_data), 64'(tbl[i].data));
      chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d.drop", i), 64'(drop_cnt), 64'(tbl[i].drop));
    end

    // Overflow: 1..20 with no consumer keeps 1..16 and drops 4.
    apply(1, 0, 0, 0);
    for (int v = 1; v <= 20; v++) apply(0, 1, v, 0);
    chk("fill.count", 64'(count), 64'd16);
    chk("fill.drop", 64'(drop_cnt), 64'd4);
    chk("fill.ovf", 64'(overflow), 64'd1);
    chk("fill.head", 64'(out_data), 64'd1);

    // Full with simultaneous pop and push: no drop, 100 enters at the tail.
    apply(0, 1, 100, 1);
    chk("fullpp.count", 64'(count), 64'd16);
    chk("fullpp.drop", 64'(drop_cnt), 64'd4);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), 64'(out_data), (k == 15) ? 64'd100 : 64'(k + 2));
      apply(0, 0, 0, 1);
    end
    chk("drain.count", 64'(count), 64'd0);
    chk("drain.valid", 64'(out_valid), 64'd0);
    chk("drain.ovf", 64'(overflow), 64'd1);
    apply(0, 0, 0, 1);
    chk("emptyrdy.count", 64'(count), 64'd0);

    // Mid-stream reset discards contents; next equal sample is still captured.
    for (int v = 200; v < 206; v++) apply(0, 1, v, 0);
    chk("six.count", 64'(count), 64'd6);
    apply(1, 1, 206, 0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.drop", 64'(drop_cnt), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    apply(0, 1, 205, 0);
    chk("post.count", 64'(count), 64'd1);
    chk("post.data", 64'(out_data), 64'd205);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      int bias;
      bias = ((c / 150) % 2 == 0) ? 15 : 85;
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 99) < bias);
      model_check("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/a0_trace_fifo.md
# a0_trace_fifo

Downstream capture stage for the single-cycle CPU top: samples the CPU's `a0` result register every cycle and records each change of value into a small FIFO. A display/host driver drains the FIFO through a valid/ready handshake. CPU timing is never affected: the CPU cannot be stalled, so samples that arrive while the FIFO is full are dropped, counted and flagged.

## Interface
- `DATA_WIDTH`, 32, width of `a0` and of FIFO entries
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `DROP_W`, 16, width of the drop counter
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, synchronous and active-high
- `a0`  in  DATA_WIDTH  CPU `a0` value, sampled every cycle
- `en`  in  1  capture enable; 0 = ignore `a0`
- `out_data`  out  DATA_WIDTH  oldest FIFO entry (show-ahead)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: at least one sample dropped since reset
- `drop_cnt`  out  DROP_W  dropped samples, saturating

## Operation
- `prev` register holds the last captured value; `prev_ok` flag marks `prev` as meaningful.
- Capture condition `cap = en && (!prev_ok || a0 != prev)`. The first enabled sample after reset is always captured, even if it is 0.
- On `cap`:
  - `prev <= a0` and `prev_ok <= 1`, whether or not the push succeeds. A dropped value is therefore not re-captured while `a0` holds it.
- Push accepted when `cap && (!full || pop)`, with `full = (count == DEPTH)`.
- Pop when `out_valid && out_ready`. Ready with the FIFO empty is a no-op.
- Drop when `cap && full && !pop`:
  - `overflow <= 1`.
  - `drop_cnt <= drop_cnt + 1`, saturating at all-ones.
- Both pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- Count update: push without pop → `count+1`; pop without push → `count-1`; both or neither → unchanged.
- `en` low does not clear `prev`/`prev_ok`.
- Only `rst` clears `overflow` and `drop_cnt`.

## Timing
- Reset values (next edge with `rst`=1):
  - `count`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0, `prev_ok`=0, pointers 0.
  - `out_data` is don't-care while `out_valid`=0; memory contents are not cleared.
- Latency: a value captured at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle) when the FIFO was empty.
- `out_data`/`out_valid` are registered-state driven and stable until the popping edge.
- Simultaneous push+pop when full: both take effect, `count` stays DEPTH, no drop.
- Simultaneous push+pop when empty: the pop is not possible (`out_valid`=0); only the push occurs.
- `rst` mid-stream discards all contents; a capture requested in the same cycle as `rst` is lost.
- Consecutive-cycle changes of `a0` produce one entry per cycle; there is no coalescing.

## Structure
- Package `a0_trace_pkg`: default `DEPTH`/`DROP_W` constants and a `cnt_t` width helper. No enums; the block has no FSM beyond the counters.
- One sub-module `sync_fifo`, parameterised (`DATA_WIDTH`, `DEPTH`), holding:
  - memory, pointers, count, full/empty logic
  - push-when-full-with-pop rule
- Top `a0_trace_fifo` holds `prev`/`prev_ok`, capture logic, drop counter and overflow flag.

## Test plan
- Reset, `en`=1, `a0`=0 held 3 cycles, `out_ready`=0 → exactly one entry (0); `count`=1, `out_valid`=1 one cycle after the first sample.
- `a0` sequence 5,5,7,7,7,9 with `out_ready`=1 → `out_data` pops 5,7,9 in order; no duplicates; `count` returns to 0.
- `out_ready`=0, DEPTH=16, `a0` = 1..20 on consecutive cycles → `count`=16 holding 1..16; `drop_cnt`=4; `overflow`=1. Then drain → 1..16 in order; `overflow` remains 1.
- Full FIFO, `out_ready`=1 while new `a0`=100 arrives → pop and push on the same edge; `count`=16; `drop_cnt` unchanged; 100 emerges last.
- `en`=0 while `a0` changes 3→4→5, then `en`=1 with `a0`=5 → single entry 5 (`prev` compared, not history).
- Fill 6 entries, assert `rst` 1 cycle → `count`=0, `out_valid`=0, `drop_cnt`=0; next enabled sample is captured even if equal to the pre-reset `prev`.
